pipeline_sequencer: RTL and testbench

//  Central sequencer for the 5-stage RISC-V pipeline. Merges these inputs into per-stage register enables and flushes:
//   - load-use stall from stall_and_bypass_control_unit
//   - execute-stage branch redirect
//   - data-memory wait handshake
//   - instruction-fetch wait
//   - debug halt/resume

---
 rtl/pipeline_ctrl_pkg.sv | 39 +++
 rtl/sat_counter.sv | 18 +
 rtl/pipeline_sequencer.sv | 146 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: state encoding,
// the per-stage control bundle and the normal-flow control rules.
package pipeline_ctrl_pkg;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      MEM_WAIT = 3'd1,
      DRAIN    = 3'd2,
      HALTED   = 3'd3
   } seq_state_t;

   localparam logic [6:0]  LOAD_OPCODE = 7'b0000011;
   localparam logic [31:0] NOP_INSTR   = 32'h00000013;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_FREEZE = 7'b00000_00;
   localparam ctrl_t CTRL_RESET  = 7'b00000_11;
   localparam ctrl_t CTRL_DRAIN  = 7'b01111_11;

   // Redirect beats load-use and fetch stalls: whatever sits in IF/ID is wrong-path.
   function automatic ctrl_t run_ctrl(input logic branch, input logic stall, input logic imem_ready);
      ctrl_t c;
      if (branch)          c = 7'b11111_11;
      else if (stall)      c = 7'b00111_01;
      else if (!imem_ready) c = 7'b01111_10;
      else                 c = 7'b11111_00;
      return c;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central 5-stage pipeline sequencer: merges hazard, redirect, memory-wait and
// debug-halt inputs into per-stage enables/flushes, plus stall/flush perf counters.
module pipeline_sequencer
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int DRAIN_CYC   = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             stall_needed,
   input  logic             branch_taken_execute,
   input  logic             dmem_req_memory,
   input  logic             dmem_ack,
   input  logic             imem_ready,
   input  logic             halt_request,
   input  logic             resume_request,
   output logic             pc_enable,
   output logic             if_id_enable,
   output logic             id_ex_enable,
   output logic             ex_mem_enable,
   output logic             mem_wb_enable,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output seq_state_t       seq_state,
   output logic             mem_timeout_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int DRN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   seq_state_t        state, state_n;
   logic [WAIT_W-1:0] wait_cnt, wait_n;
   logic [DRN_W-1:0]  drain_cnt, drain_n;
   logic              halt_pend, halt_n;
   logic              err, err_n;
   logic              mem_freeze;
   ctrl_t             ctrl;
   logic              stall_inc, flush_inc;

   assign mem_freeze = dmem_req_memory && !dmem_ack;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN;
         wait_cnt  <= '0;
         drain_cnt <= '0;
         halt_pend <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         wait_cnt  <= wait_n;
         drain_cnt <= drain_n;
         halt_pend <= halt_n;
         err       <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      drain_n = drain_cnt;
      halt_n  = halt_pend;
      err_n   = err;
      case (state)
         RUN: begin
            if (mem_freeze) begin
               state_n = MEM_WAIT;
               wait_n  = WAIT_W'(1);
               halt_n  = halt_request;
            end else if (halt_request) begin
               state_n = DRAIN;
               drain_n = '0;
            end
         end
         MEM_WAIT: begin
            if (halt_request) halt_n = 1'b1;
            if (dmem_ack) begin
               state_n = (halt_pend || halt_request) ? DRAIN : RUN;
               halt_n  = 1'b0;
               drain_n = '0;
            end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
               // Memory never answered: park for good, only reset recovers.
               err_n   = 1'b1;
               state_n = HALTED;
               halt_n  = 1'b0;
            end else begin
               wait_n = wait_cnt + WAIT_W'(1);
            end
         end
         DRAIN: begin
            if (!mem_freeze) begin
               if (drain_cnt == DRN_W'(DRAIN_CYC - 1)) state_n = HALTED;
               else                                   drain_n = drain_cnt + DRN_W'(1);
            end
         end
         HALTED: begin
            if (resume_request && !err) state_n = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   always_comb begin
      ctrl = CTRL_FREEZE;
      case (state)
         RUN:      ctrl = mem_freeze ? CTRL_FREEZE : run_ctrl(branch_taken_execute, stall_needed, imem_ready);
         MEM_WAIT: ctrl = dmem_ack ? run_ctrl(branch_taken_execute, stall_needed, imem_ready) : CTRL_FREEZE;
         DRAIN:    ctrl = mem_freeze ? CTRL_FREEZE : CTRL_DRAIN;
         default:  ctrl = CTRL_FREEZE;
      endcase
      if (!reset_n) ctrl = CTRL_RESET;
   end

   assign pc_enable         = ctrl.pc_en;
   assign if_id_enable      = ctrl.if_id_en;
   assign id_ex_enable      = ctrl.id_ex_en;
   assign ex_mem_enable     = ctrl.ex_mem_en;
   assign mem_wb_enable     = ctrl.mem_wb_en;
   assign if_id_flush       = ctrl.if_id_flush;
   assign id_ex_flush       = ctrl.id_ex_flush;
   assign seq_state         = state;
   assign mem_timeout_error = err;

   assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) && !ctrl.pc_en;
   assign flush_inc = branch_taken_execute &&
                      (((state == RUN) && !mem_freeze) || ((state == MEM_WAIT) && dmem_ack));

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (stall_inc),
      .count   (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (flush_inc),
      .count   (flush_events)
   );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: driver pushes hand-written expectations
// per cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_sequencer;
   import pipeline_ctrl_pkg::*;

   localparam int CNT_W = 8;
   localparam int MEM_TIMEOUT = 8;
   localparam int DRAIN_CYC = 3;

   // control: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
   localparam logic [6:0] C_RUN = 7'b11111_00;
   localparam logic [6:0] C_BR  = 7'b11111_11;
   localparam logic [6:0] C_LU  = 7'b00111_01;
   localparam logic [6:0] C_IM  = 7'b01111_10;
   localparam logic [6:0] C_FRZ = 7'b00000_00;
   localparam logic [6:0] C_DRN = 7'b01111_11;
   localparam logic [6:0] C_RST = 7'b00000_11;

   // stimulus: {stall, branch, req, ack, imem_ready, halt, resume}
   localparam logic [6:0] S_IDLE    = 7'b0000100;
   localparam logic [6:0] S_LU      = 7'b1000100;
   localparam logic [6:0] S_BRLU    = 7'b1100100;
   localparam logic [6:0] S_BR      = 7'b0100100;
   localparam logic [6:0] S_NOIM    = 7'b0000000;
   localparam logic [6:0] S_BRNOIM  = 7'b0100000;
   localparam logic [6:0] S_WAIT    = 7'b0010100;
   localparam logic [6:0] S_ACK     = 7'b0011100;
   localparam logic [6:0] S_ACKBR   = 7'b0111100;
   localparam logic [6:0] S_HALT    = 7'b0000110;
   localparam logic [6:0] S_WAITHLT = 7'b0010110;
   localparam logic [6:0] S_RESUME  = 7'b0000101;

   typedef struct packed {
      logic [6:0]       ctrl;
      seq_state_t       state;
      logic             err;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic stall_needed = 1'b0, branch_taken_execute = 1'b0, dmem_req_memory = 1'b0;
   logic dmem_ack = 1'b0, imem_ready = 1'b1, halt_request = 1'b0, resume_request = 1'b0;
   logic pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
   logic if_id_flush, id_ex_flush, mem_timeout_error;
   seq_state_t seq_state;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   exp_t exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   logic [CNT_W-1:0] m_stall = '0;
   logic [CNT_W-1:0] m_flush = '0;

   pipeline_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .stall_needed         (stall_needed),
      .branch_taken_execute (branch_taken_execute),
      .dmem_req_memory      (dmem_req_memory),
      .dmem_ack             (dmem_ack),
      .imem_ready           (imem_ready),
      .halt_request         (halt_request),
      .resume_request       (resume_request),
      .pc_enable            (pc_enable),
      .if_id_enable         (if_id_enable),
      .id_ex_enable         (id_ex_enable),
      .ex_mem_enable        (ex_mem_enable),
      .mem_wb_enable        (mem_wb_enable),
      .if_id_flush          (if_id_flush),
      .id_ex_flush          (id_ex_flush),
      .seq_state            (seq_state),
      .mem_timeout_error    (mem_timeout_error),
      .stall_cycles         (stall_cycles),
      .flush_events         (flush_events)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] dut_ctrl();
      return {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
              if_id_flush, id_ex_flush};
   endfunction

   task automatic drive(input logic [6:0] s);
      {stall_needed, branch_taken_execute, dmem_req_memory, dmem_ack,
       imem_ready, halt_request, resume_request} = s;
   endtask

   // One clock of stimulus; counters are expected to show their value before this cycle's bump.
   task automatic cyc(input logic [6:0] s, input logic [6:0] ectrl, input seq_state_t est,
                      input logic eerr, input logic inc_s, input logic inc_f);
      exp_t e;
      @(posedge clock); #1;
      drive(s);
      e.ctrl = ectrl; e.state = est; e.err = eerr; e.stall = m_stall; e.flush = m_flush;
      exp_q.push_back(e);
      if (inc_s && (m_stall != '1)) m_stall = m_stall + 1'b1;
      if (inc_f && (m_flush != '1)) m_flush = m_flush + 1'b1;
   endtask

   // Reset asserted between edges; outputs must take reset values immediately.
   task automatic do_reset();
      @(negedge clock); #2;
      reset_n = 1'b0;
      #1;
      chk("rst_ctrl", 32'(dut_ctrl()), 32'(C_RST));
      chk("rst_state", 32'(seq_state), 32'(RUN));
      chk("rst_err", 32'(mem_timeout_error), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_flush", 32'(flush_events), 32'd0);
      drive(S_IDLE);
      m_stall = '0;
      m_flush = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ctrl", 32'(dut_ctrl()), 32'(e.ctrl));
         chk("state", 32'(seq_state), 32'(e.state));
         chk("timeout_err", 32'(mem_timeout_error), 32'(e.err));
         chk("stall_cycles", 32'(stall_cycles), 32'(e.stall));
         chk("flush_events", 32'(flush_events), 32'(e.flush));
      end
   end

   initial begin
      do_reset();

      // normal flow, load-use, branch overriding load-use and fetch stall
      cyc(S_IDLE,   C_RUN, RUN, 0, 0, 0);
      cyc(S_LU,     C_LU,  RUN, 0, 1, 0);
      cyc(S_BRLU,   C_BR,  RUN, 0, 0, 1);
      cyc(S_NOIM,   C_IM,  RUN, 0, 1, 0);
      cyc(S_BRNOIM, C_BR,  RUN, 0, 0, 1);
      cyc(S_ACK,    C_RUN, RUN, 0, 0, 0);
      cyc(S_IDLE,   C_RUN, RUN, 0, 0, 0);

      // memory wait: 4 frozen cycles, then ack cycle runs normally
      cyc(S_WAIT, C_FRZ, RUN, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(S_WAIT, C_FRZ, MEM_WAIT, 0, 1, 0);
      cyc(S_ACK,   C_RUN, MEM_WAIT, 0, 0, 0);
      cyc(S_IDLE,  C_RUN, RUN, 0, 0, 0);
      // ack coinciding with a redirect
      cyc(S_WAIT,  C_FRZ, RUN, 0, 1, 0);
      cyc(S_ACKBR, C_BR,  MEM_WAIT, 0, 0, 1);
      cyc(S_IDLE,  C_RUN, RUN, 0, 0, 0);

      // halt: drain ignores redirect, freezes on memory wait without advancing
      cyc(S_HALT, C_RUN, RUN, 0, 0, 0);
      cyc(S_IDLE, C_DRN, DRAIN, 0, 0, 0);
      cyc(S_BR,   C_DRN, DRAIN, 0, 0, 0);
      cyc(S_WAIT, C_FRZ, DRAIN, 0, 0, 0);
      cyc(S_ACK,  C_DRN, DRAIN, 0, 0, 0);
      cyc(S_HALT, C_FRZ, HALTED, 0, 0, 0);
      cyc(S_RESUME, C_FRZ, HALTED, 0, 0, 0);
      cyc(S_IDLE, C_RUN, RUN, 0, 0, 0);

      // halt during a memory wait is deferred to the ack
      cyc(S_WAITHLT, C_FRZ, RUN, 0, 1, 0);
      cyc(S_WAIT,    C_FRZ, MEM_WAIT, 0, 1, 0);
      cyc(S_ACK,     C_RUN, MEM_WAIT, 0, 0, 0);
      for (int i = 0; i < DRAIN_CYC; i++) cyc(S_IDLE, C_DRN, DRAIN, 0, 0, 0);
      cyc(S_RESUME, C_FRZ, HALTED, 0, 0, 0);
      cyc(S_IDLE,   C_RUN, RUN, 0, 0, 0);

      // timeout: 8 unanswered MEM_WAIT cycles, then sticky error and resume ignored
      cyc(S_WAIT, C_FRZ, RUN, 0, 1, 0);
      for (int i = 0; i < MEM_TIMEOUT; i++) cyc(S_WAIT, C_FRZ, MEM_WAIT, 0, 1, 0);
      cyc(S_RESUME, C_FRZ, HALTED, 1, 0, 0);
      cyc(S_RESUME, C_FRZ, HALTED, 1, 0, 0);
      cyc(S_IDLE,   C_FRZ, HALTED, 1, 0, 0);
      do_reset();
      cyc(S_IDLE, C_RUN, RUN, 0, 0, 0);

      // asynchronous reset in the middle of a memory wait
      cyc(S_LU,   C_LU,  RUN, 0, 1, 0);
      cyc(S_WAIT, C_FRZ, RUN, 0, 1, 0);
      cyc(S_WAIT, C_FRZ, MEM_WAIT, 0, 1, 0);
      do_reset();
      cyc(S_IDLE, C_RUN, RUN, 0, 0, 0);

      // counter saturation at all-ones
      for (int i = 0; i < 260; i++) cyc(S_BR, C_BR, RUN, 0, 0, 1);
      for (int i = 0; i < 260; i++) cyc(S_LU, C_LU, RUN, 0, 1, 0);
      cyc(S_IDLE, C_RUN, RUN, 0, 0, 0);
      chk("model_stall_sat", 32'(m_stall), 32'(8'hFF));
      chk("model_flush_sat", 32'(m_flush), 32'(8'hFF));

      repeat (3) @(posedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
